// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package rf_wb_arbiter_pkg;

  localparam int unsigned WB_REQ_WD = 1 + 5 + 32 + 32;

  typedef struct packed {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] wdata;
    logic [31:0] pc;
  } wb_req_t;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] wdata;
    logic [31:0] pc;
  } lu_entry_t;

  // Hazard bus contribution: one valid bit plus a 5-bit dest per pending entry.
  function automatic int unsigned pend_bus_wd(input int unsigned depth);
    return depth * 6;
  endfunction

endpackage

// File: rtl/lu_result_fifo.sv
// Synchronous FIFO for long-latency results; per-entry occupancy and dest are exported.
module lu_result_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  lu_entry_t            push_data_i,
  output lu_entry_t            head_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DEPTH-1:0]     pend_valid_o,
  output logic [5*DEPTH-1:0]   pend_dest_o
);

  localparam int PW = $clog2(DEPTH);

  lu_entry_t          mem_q [DEPTH];
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PW:0]        cnt_q, cnt_d;

  assign full_o       = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o      = (cnt_q == '0);
  assign head_o       = mem_q[rd_ptr_q];
  assign pend_valid_o = vld_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      pend_dest_o[5*i +: 5] = mem_q[i].dest;
    end
  end

  always_comb begin
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (pop_i) begin
      vld_d[rd_ptr_q] = 1'b0;
      cnt_d           = cnt_d - 1'b1;
    end
    if (push_i) begin
      vld_d[wr_ptr_q] = 1'b1;
      cnt_d           = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Payload storage is not reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: arbitrates writeback against buffered long-latency results.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ws_req_valid,
  input  logic                 ws_req_we,
  input  logic [4:0]           ws_req_dest,
  input  logic [31:0]          ws_req_wdata,
  input  logic [31:0]          ws_req_pc,
  output logic                 ws_req_ready,
  input  logic                 lu_req_valid,
  input  logic [4:0]           lu_req_dest,
  input  logic [31:0]          lu_req_wdata,
  input  logic [31:0]          lu_req_pc,
  output logic                 lu_req_ready,
  output logic [DEPTH-1:0]     pend_valid,
  output logic [5*DEPTH-1:0]   pend_dest,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_wen,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  lu_entry_t               head;
  lu_entry_t               lu_in;
  logic                    fifo_full, fifo_empty;
  logic                    push, head_win, dest_hit;
  logic [SW-1:0]           starve_q, starve_d;
  wb_req_t                 wr_d, wr_view;
  logic [WB_REQ_WD-1:0]    wr_q;

  assign lu_in        = '{dest: lu_req_dest, wdata: lu_req_wdata, pc: lu_req_pc};
  assign lu_req_ready = !fifo_full;
  assign push         = lu_req_valid && !fifo_full;

  lu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .pop_i        (head_win),
    .push_data_i  (lu_in),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .pend_valid_o (pend_valid),
    .pend_dest_o  (pend_dest)
  );

  always_comb begin
    dest_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pend_valid[i] && pend_dest[5*i +: 5] == ws_req_dest) dest_hit = 1'b1;
    end
  end

  // An older pending write to the same GPR must land before the writeback one.
  assign head_win = !fifo_empty &&
                    (!ws_req_valid || fifo_full || (starve_q == SW'(STARVE_MAX)) ||
                     (ws_req_we && ws_req_dest != 5'd0 && dest_hit));
  assign ws_req_ready = !head_win;

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || head_win)                         starve_d = '0;
    else if (ws_req_valid && starve_q != SW'(STARVE_MAX)) starve_d = starve_q + 1'b1;
  end

  always_comb begin
    wr_d    = wb_req_t'(wr_q);
    wr_d.we = 1'b0;
    if (head_win) begin
      wr_d = '{we: head.dest != 5'd0, dest: head.dest, wdata: head.wdata, pc: head.pc};
    end else if (ws_req_valid) begin
      wr_d = '{we: ws_req_we && ws_req_dest != 5'd0, dest: ws_req_dest,
               wdata: ws_req_wdata, pc: ws_req_pc};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      wr_q     <= '0;
    end else begin
      starve_q <= starve_d;
      wr_q     <= wr_d;
    end
  end

  assign wr_view           = wr_q;
  assign rf_we             = wr_view.we;
  assign rf_waddr          = wr_view.dest;
  assign rf_wdata          = wr_view.wdata;
  assign debug_wb_pc       = wr_view.pc;
  assign debug_wb_rf_wen   = {4{wr_view.we}};
  assign debug_wb_rf_wnum  = wr_view.dest;
  assign debug_wb_rf_wdata = wr_view.wdata;

endmodule
